cmd_arbiter: RTL and testbench
==============================

# cmd_arbiter

Shares the single command processor between the two command sources of the Knight robot: commands received over Bluetooth (UART wrapper) and commands generated by the tour command unit. Each command is granted to one owner and offered to cmd_proc. The arbiter holds that ownership until cmd_proc signals completion with send_resp, then routes the completion pulse back to the owner only. It sits between the UART wrapper, the tour command unit and cmd_proc, and replaces a direct cmd/cmd_rdy mux.

## Interface
- CMD_W, 16, command width
- STARVE_MAX, 4, max consecutive tour grants while a UART command waits
- TIMEOUT_CYC, 1048576, execution watchdog limit in clocks (used only with CMD_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous active-low
- cmd_UART  in  CMD_W  command from UART wrapper
- cmd_rdy_UART  in  1  UART command pending (level, held until cleared)
- clr_cmd_rdy_UART  out  1  consume pulse to UART wrapper
- cmd_tour  in  CMD_W  command from tour command unit
- cmd_rdy_tour  in  1  tour command pending (level)
- clr_cmd_rdy_tour  out  1  consume pulse to tour command unit
- cmd  out  CMD_W  registered command to cmd_proc
- cmd_rdy  out  1  registered command-valid to cmd_proc
- clr_cmd_rdy  in  1  cmd_proc has accepted cmd
- send_resp  in  1  cmd_proc has finished the command
- send_resp_UART  out  1  completion pulse to UART side
- send_resp_tour  out  1  completion pulse to tour side
- owner  out  2  current grant: 2'b00 none, 2'b01 UART, 2'b10 tour
- timeout  out  1  one-cycle watchdog pulse; constant 0 without CMD_ARB_TIMEOUT_EN

## Operation
- States:
  - IDLE: no grant is held.
  - OFFER: cmd_rdy=1 and the command waits for cmd_proc to accept it.
  - EXEC: the command is accepted and the arbiter waits for send_resp.
- Grant selection (IDLE, when either cmd_rdy_* is high):
  - Only one source requests: that source wins.
  - Both sources request: tour wins unless starve_cnt==STARVE_MAX, in which case UART wins.
- On a grant:
  - Latch the winner's command into cmd.
  - Set owner to the winner and go to OFFER.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on a tour grant made while cmd_rdy_UART is high.
  - Clears on a UART grant.
  - Width is $clog2(STARVE_MAX+1).
- OFFER, when clr_cmd_rdy=1:
  - clr_cmd_rdy_<owner> = clr_cmd_rdy in the same cycle (combinational, gated by state and owner).
  - Next state EXEC, cmd_rdy<=0.
- EXEC, when send_resp=1:
  - send_resp_<owner> = send_resp in the same cycle (combinational).
  - Next state IDLE, owner<=none.
- Ignored inputs:
  - clr_cmd_rdy outside OFFER is ignored; no clr pulse reaches either source.
  - send_resp outside EXEC is ignored; no pulse is forwarded.
- A source that drops cmd_rdy_* while in OFFER does not withdraw its command; the latched command stays offered.
- A command latched into cmd is never changed until the next grant.
- Reset mid-operation: every state element returns to its reset value; any in-flight grant is abandoned.

## Timing
- Reset values: state=IDLE, cmd=0, cmd_rdy=0, owner=0, starve_cnt=0, all pulse outputs 0, watchdog count 0.
- Grant latency: a request sampled at edge t gives cmd/cmd_rdy/owner valid after edge t (one cycle).
- clr_cmd_rdy_* and send_resp_* have zero latency relative to their inputs.
- After EXEC→IDLE, IDLE lasts at least one cycle, so back-to-back commands are spaced ≥3 cycles.
- Sources must deassert cmd_rdy_* no later than the edge after their clr pulse.

## Configuration
- CMD_ARB_TIMEOUT_EN defined:
  - A watchdog counts EXEC cycles and clears on entering EXEC.
  - If TIMEOUT_CYC cycles pass without send_resp, go to IDLE, clear owner, and pulse timeout for one cycle; no send_resp_* is forwarded.
  - If send_resp arrives in the timeout cycle, send_resp wins and timeout stays 0.
- CMD_ARB_TIMEOUT_EN not defined:
  - No counter exists, timeout is tied to 0, and EXEC waits indefinitely.

## Structure
- Package cmd_arb_pkg holds:
  - state enum (IDLE, OFFER, EXEC);
  - owner enum (OWN_NONE=2'b00, OWN_UART=2'b01, OWN_TOUR=2'b10).
- Sub-module cmd_arb_wdog (counter plus terminal-count pulse) is instantiated only under CMD_ARB_TIMEOUT_EN.

## Test plan
- Tour only, cmd_tour=16'h2002: cmd_rdy rises one cycle later with cmd=16'h2002 and owner=2'b10; after clr_cmd_rdy, clr_cmd_rdy_tour pulses; after send_resp, send_resp_tour pulses and send_resp_UART stays 0.
- UART only, cmd_UART=16'h4000: cmd=16'h4000 and owner=2'b01; send_resp is routed to send_resp_UART only.
- Both sources held high continuously with STARVE_MAX=4: grant order is T,T,T,T,U,T,T,T,T,U.
- clr_cmd_rdy pulsed in IDLE and send_resp pulsed in OFFER: no output pulses, state unchanged.
- rst_n asserted during EXEC: outputs return to 0 immediately; after release a pending tour request is granted fresh.
- With CMD_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no send_resp: timeout pulses 16 cycles after entering EXEC, owner=0, and the next request is granted.

Source files
------------

// File: rtl/cmd_arb_pkg.sv
// Shared types for the Knight command arbiter: FSM state and grant owner encodings.
package cmd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        EXEC  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_UART = 2'b01,
        OWN_TOUR = 2'b10
    } owner_t;

endpackage

// File: rtl/cmd_arb_wdog.sv
// Execution watchdog for cmd_arbiter: counts run cycles, flags the LIMIT-th one.
// Only instantiated when CMD_ARB_TIMEOUT_EN is defined.
module cmd_arb_wdog #(
    parameter int unsigned LIMIT = 1048576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tc
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // tc marks the LIMIT-th consecutive run cycle
    assign tc = run && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/cmd_arbiter.sv
// Arbitrates cmd_proc between the UART wrapper and the tour command unit.
// Optional execution watchdog enabled by defining CMD_ARB_TIMEOUT_EN.
module cmd_arbiter
    import cmd_arb_pkg::*;
#(
    parameter int unsigned CMD_W       = 16,
    parameter int unsigned STARVE_MAX  = 4,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    input  logic [CMD_W-1:0] cmd_tour,
    input  logic             cmd_rdy_tour,
    output logic             clr_cmd_rdy_tour,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic             send_resp_UART,
    output logic             send_resp_tour,
    output logic [1:0]       owner,
    output logic             timeout
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_t       state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             cmd_rdy_q;
    logic             wd_tc;

`ifdef CMD_ARB_TIMEOUT_EN
    cmd_arb_wdog #(
        .LIMIT(TIMEOUT_CYC)
    ) u_wdog (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_q != EXEC),
        .run  (state_q == EXEC),
        .tc   (wd_tc)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign wd_tc = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        cmd_d            = cmd_q;
        starve_d         = starve_q;
        clr_cmd_rdy_UART = 1'b0;
        clr_cmd_rdy_tour = 1'b0;
        send_resp_UART   = 1'b0;
        send_resp_tour   = 1'b0;
        timeout          = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_rdy_UART || cmd_rdy_tour) begin
                    state_d = OFFER;
                    // tour has priority unless UART has been passed over STARVE_MAX times
                    if (cmd_rdy_tour && !(cmd_rdy_UART && starve_q == SW'(STARVE_MAX))) begin
                        owner_d = OWN_TOUR;
                        cmd_d   = cmd_tour;
                        if (cmd_rdy_UART) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        owner_d  = OWN_UART;
                        cmd_d    = cmd_UART;
                        starve_d = '0;
                    end
                end
            end
            OFFER: begin
                if (clr_cmd_rdy) begin
                    clr_cmd_rdy_UART = (owner_q == OWN_UART);
                    clr_cmd_rdy_tour = (owner_q == OWN_TOUR);
                    state_d          = EXEC;
                end
            end
            EXEC: begin
                if (send_resp) begin
                    send_resp_UART = (owner_q == OWN_UART);
                    send_resp_tour = (owner_q == OWN_TOUR);
                    state_d        = IDLE;
                    owner_d        = OWN_NONE;
                end else if (wd_tc) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            cmd_q     <= '0;
            starve_q  <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            starve_q  <= starve_d;
            cmd_rdy_q <= (state_d == OFFER);
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Randomized self-checking bench for cmd_arbiter against a transaction-level model.
// Honours CMD_ARB_TIMEOUT_EN when the design is built with the watchdog.
module tb_cmd_arbiter;

    localparam int unsigned CMD_W       = 16;
    localparam int unsigned STARVE_MAX  = 4;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic             clk;
    logic             rst_n;
    logic [CMD_W-1:0] cmd_UART, cmd_tour, cmd;
    logic             cmd_rdy_UART, cmd_rdy_tour, cmd_rdy;
    logic             clr_cmd_rdy_UART, clr_cmd_rdy_tour, clr_cmd_rdy;
    logic             send_resp, send_resp_UART, send_resp_tour, timeout;
    logic [1:0]       owner;

    cmd_arbiter #(
        .CMD_W      (CMD_W),
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_UART        (cmd_UART),
        .cmd_rdy_UART    (cmd_rdy_UART),
        .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
        .cmd_tour        (cmd_tour),
        .cmd_rdy_tour    (cmd_rdy_tour),
        .clr_cmd_rdy_tour(clr_cmd_rdy_tour),
        .cmd             (cmd),
        .cmd_rdy         (cmd_rdy),
        .clr_cmd_rdy     (clr_cmd_rdy),
        .send_resp       (send_resp),
        .send_resp_UART  (send_resp_UART),
        .send_resp_tour  (send_resp_tour),
        .owner           (owner),
        .timeout         (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: one held grant, accepted or not, plus fairness count
    bit           m_busy, m_acc;
    int           m_who;
    logic [15:0]  m_cmd;
    int           m_starve, m_exec;

    // Source behaviour and cmd_proc policy (0 never, 1 random, 2 cooperative, 3 always)
    logic [15:0]  q_u[$], q_t[$];
    bit           drop_en;
    int           clr_mode, resp_mode;
    int           glog[$];
    bit           prev_rdy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_who = 0; m_cmd = '0;
        m_starve = 0; m_exec = 0; prev_rdy = 0;
    endtask

    task automatic check_outputs(input string ph);
        bit ex_rdy, ex_to;
        ex_rdy = m_busy && !m_acc;
        ex_to  = 1'b0;
`ifdef CMD_ARB_TIMEOUT_EN
        ex_to  = m_busy && m_acc && !send_resp && (m_exec == int'(TIMEOUT_CYC) - 1);
`endif
        check_eq({ph, ".cmd"},      32'(cmd),     32'(m_cmd));
        check_eq({ph, ".cmd_rdy"},  32'(cmd_rdy), 32'(ex_rdy));
        check_eq({ph, ".owner"},    32'(owner),   32'(m_who));
        check_eq({ph, ".clr_U"},    32'(clr_cmd_rdy_UART), 32'(ex_rdy && clr_cmd_rdy && m_who == 1));
        check_eq({ph, ".clr_T"},    32'(clr_cmd_rdy_tour), 32'(ex_rdy && clr_cmd_rdy && m_who == 2));
        check_eq({ph, ".resp_U"},   32'(send_resp_UART), 32'(m_busy && m_acc && send_resp && m_who == 1));
        check_eq({ph, ".resp_T"},   32'(send_resp_tour), 32'(m_busy && m_acc && send_resp && m_who == 2));
        check_eq({ph, ".timeout"},  32'(timeout), 32'(ex_to));
    endtask

    function automatic logic pick(input int mode, input bit coop);
        case (mode)
            1:       return logic'($urandom_range(1, 0));
            2:       return coop;
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the next one
    task automatic run_cycle();
        bit pop_u, pop_t, uart_wins;
        cmd_rdy_UART = (q_u.size() != 0) && !(drop_en && $urandom_range(5, 0) == 0);
        cmd_rdy_tour = (q_t.size() != 0) && !(drop_en && $urandom_range(5, 0) == 0);
        cmd_UART     = (q_u.size() != 0) ? q_u[0] : 16'($urandom);
        cmd_tour     = (q_t.size() != 0) ? q_t[0] : 16'($urandom);
        clr_cmd_rdy  = pick(clr_mode, m_busy && !m_acc);
        send_resp    = pick(resp_mode, m_busy && m_acc);

        @(negedge clk);
        check_outputs("cyc");
        if (cmd_rdy && !prev_rdy) glog.push_back(int'(owner));
        prev_rdy = cmd_rdy;

        pop_u = m_busy && !m_acc && clr_cmd_rdy && m_who == 1;
        pop_t = m_busy && !m_acc && clr_cmd_rdy && m_who == 2;
        if (!m_busy) begin
            if (cmd_rdy_UART || cmd_rdy_tour) begin
                uart_wins = cmd_rdy_UART && (!cmd_rdy_tour || m_starve >= int'(STARVE_MAX));
                m_busy = 1; m_acc = 0;
                if (uart_wins) begin
                    m_who = 1; m_cmd = cmd_UART; m_starve = 0;
                end else begin
                    m_who = 2; m_cmd = cmd_tour;
                    if (cmd_rdy_UART && m_starve < int'(STARVE_MAX)) m_starve++;
                end
            end
        end else if (!m_acc) begin
            if (clr_cmd_rdy) begin
                m_acc = 1; m_exec = 0;
            end
        end else if (send_resp) begin
            m_busy = 0; m_who = 0;
        end else begin
`ifdef CMD_ARB_TIMEOUT_EN
            if (m_exec == int'(TIMEOUT_CYC) - 1) begin
                m_busy = 0; m_who = 0;
            end else begin
                m_exec++;
            end
`endif
        end

        @(posedge clk);
        #1;
        if (pop_u) void'(q_u.pop_front());
        if (pop_t) void'(q_t.pop_front());
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic drain();
        int n;
        drop_en = 0; clr_mode = 2; resp_mode = 2;
        n = 0;
        while ((q_u.size() != 0 || q_t.size() != 0 || m_busy) && n < 400) begin
            run_cycle();
            n++;
        end
        check_eq("drain_done", 32'(q_u.size() + q_t.size() + int'(m_busy)), 32'd0);
    endtask

    int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    initial begin
        int n;
        rst_n = 1'b0;
        cmd_UART = '0; cmd_tour = '0;
        cmd_rdy_UART = 0; cmd_rdy_tour = 0; clr_cmd_rdy = 0; send_resp = 0;
        drop_en = 0; clr_mode = 0; resp_mode = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        // single tour command, then single UART command
        clr_mode = 2; resp_mode = 2;
        q_t.push_back(16'h2002);
        run_n(5);
        q_u.push_back(16'h4000);
        run_n(5);

        // stray handshakes in IDLE, then send_resp while a command is still offered
        clr_mode = 3; resp_mode = 3;
        run_n(3);
        clr_mode = 0;
        q_t.push_back(16'h1234);
        run_n(4);
        clr_mode = 2; resp_mode = 2;
        run_n(4);

        // both sources held: fairness order
        glog.delete();
        for (int i = 0; i < 10; i++) q_t.push_back(16'h3000 + 16'(i));
        for (int i = 0; i < 3; i++)  q_u.push_back(16'h5000 + 16'(i));
        n = 0;
        while (glog.size() < 10 && n < 200) begin
            run_cycle();
            n++;
        end
        check_eq("grant_count", 32'(glog.size()), 32'd10);
        for (int i = 0; i < 10 && i < glog.size(); i++)
            check_eq("grant_order", 32'(glog[i]), 32'(exp_order[i]));
        drain();

        // reset while executing, fresh tour grant afterwards
        resp_mode = 0;
        q_t.push_back(16'h6006);
        run_n(4);
        check_eq("in_exec_owner", 32'(owner), 32'd2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_exec");
        repeat (2) @(posedge clk);
        @(negedge clk);
        q_t.push_back(16'h6007);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        resp_mode = 2;
        run_n(6);

        // no completion for a long time: wait forever, or watchdog fires
        resp_mode = 0;
        q_u.push_back(16'h7007);
        run_n(40);
        resp_mode = 2;
        run_n(4);
        drain();

        // randomized traffic
        drop_en = 1; clr_mode = 1; resp_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            if (q_u.size() < 3 && $urandom_range(7, 0) == 0) q_u.push_back(16'($urandom));
            if (q_t.size() < 3 && $urandom_range(7, 0) == 0) q_t.push_back(16'($urandom));
            run_cycle();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
